square_draw_arbiter: RTL and testbench
======================================

# square_draw_arbiter

Shares the single VGA pixel-write port between up to N_REQ independent 4x4-square draw requesters, such as the note lanes, the hit marker and the erase logic. It grants one requester at a time in round-robin order, latches that requester's coordinates and colour, and emits the 16 pixel writes of the square one per clock. It then acknowledges the requester. It sits between the game logic and the VGA adapter and replaces free-running square drawing, so a square is only drawn when requested and never overlaps another requester's writes.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  reset, synchronous, active-low
- req  in  N_REQ  per-requester draw request; level, held until done
- req_x  in  8*N_REQ  top-left x of requester i at bits [8i+7:8i]
- req_y  in  7*N_REQ  top-left y of requester i at bits [7i+6:7i]
- req_colour  in  3*N_REQ  colour of requester i at bits [3i+2:3i]
- req_erase  in  N_REQ  1 = draw in black (colour 3'b000), overriding req_colour
- done  out  N_REQ  one-cycle acknowledge to the granted requester
- busy  out  1  high in DRAW and DONE
- vga_x  out  8  pixel x to the VGA adapter
- vga_y  out  7  pixel y to the VGA adapter
- vga_colour  out  3  pixel colour to the VGA adapter
- vga_plot  out  1  pixel write enable

## Operation
- State machine:
  - IDLE: if any req bit is high at a posedge, choose the winner, latch its x, y and effective colour, set cnt=0, and go to DRAW. Otherwise stay in IDLE.
  - DRAW: vga_plot=1. cnt increments each cycle. When cnt=15, go to DONE.
  - DONE: done[gnt]=1, vga_plot=0, then go to IDLE.
- Arbitration is round-robin:
  - Search req starting at index ptr and wrapping modulo N_REQ. The first set bit wins.
  - On a grant, ptr <= winner+1 mod N_REQ.
  - Reset value of ptr is 0, so index 0 has top priority after reset.
- Effective colour = req_erase[i] ? 3'b000 : req_colour[i], sampled at grant.
- Pixel order: cnt[1:0] is the x offset and cnt[3:2] is the y offset. The square is drawn row-major: (0,0),(1,0),(2,0),(3,0),(0,1)…(3,3).
- vga_x = lat_x + cnt[1:0], truncated to 8 bits (255+1 wraps to 0).
- vga_y = lat_y + cnt[3:2], truncated to 7 bits (127+1 wraps to 0).
- vga_colour = latched effective colour during DRAW, 0 otherwise.
- vga_x and vga_y are 0 outside DRAW.
- Inputs of the granted requester are ignored after the grant cycle; changes mid-draw do not affect the square.
- Requesters deassert req on the cycle done is seen. A req still high in the IDLE cycle after DONE is arbitrated again at lowest priority relative to ptr.
- A req asserted while busy waits; requests are never dropped.
- Reset in any state:
  - state=IDLE, cnt=0, ptr=0.
  - All outputs 0: done=0, busy=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
  - A draw aborted by reset issues no done pulse.

## Timing
- Grant edge: the posedge in IDLE at which a req is seen. DRAW occupies the next 16 cycles (vga_plot high for exactly 16 consecutive cycles). DONE follows for 1 cycle.
- Latency from req sampled to first pixel: 1 cycle (first pixel valid in the cycle after the grant edge).
- Latency from req sampled to done: 17 cycles.
- Back-to-back throughput: one square per 18 cycles (IDLE, 16×DRAW, DONE).
- Outputs are decoded from registered state, cnt and the latch, with no combinational path from req to vga_*.
- done is one-hot or zero, and never high outside DONE.

## Test plan
- Single request: req[0]=1, x=10, y=20, colour=3'b101. Required response:
  - 16 plot cycles from (10,20) to (13,23), row-major, colour 5.
  - done[0] high 17 cycles after the grant edge, for 1 cycle.
  - busy low afterwards.
- Simultaneous requests: req=4'b1010 from reset. Required response:
  - Requester 1 is served first, then requester 3.
  - done[1], then done[3], 18 cycles apart.
  - No plot in the IDLE gap.
- Fairness: all four req held high continuously. Required response:
  - Grant order 0,1,2,3,0,…
  - Each done spaced 18 cycles.
  - No requester served twice before the others.
- Wrap and erase: x=254, y=126, req_erase=1, colour=3'b111. Required response:
  - Pixels span x 254,255,0,1 and y 126,127,0,1.
  - vga_colour=0 on all 16 pixels.
- Input change mid-draw: change req_x of the granted requester at pixel 5. Required response: all 16 pixels use the originally latched x.
- Reset mid-draw: resetn=0 at pixel 8. Required response:
  - Next cycle vga_plot=0, busy=0, done=0, ptr=0.
  - A subsequent req[2] is served normally from IDLE.

Source files
------------

// File: rtl/square_draw_arbiter.sv
// square_draw_arbiter: shares one VGA pixel-write port between N_REQ
// 4x4-square draw requesters, granting them round-robin.
//
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   req           per-requester draw request (level, held until done)
//   req_x/y       packed top-left coordinates, 8 / 7 bits per requester
//   req_colour    packed colour, 3 bits per requester
//   req_erase     draw black instead of req_colour
//   done          one-cycle acknowledge to the served requester
//   busy          high while a square is drawn or acknowledged
//   vga_*         pixel write port to the VGA adapter
module square_draw_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_x,
  input  logic [7*N_REQ-1:0] req_y,
  input  logic [3*N_REQ-1:0] req_colour,
  input  logic [N_REQ-1:0]   req_erase,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    cnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          any;
  logic [7:0]    lat_x;
  logic [6:0]    lat_y;
  logic [2:0]    lat_c;

  // Scan from the farthest offset down so the set bit
  // closest to ptr is the last one written and wins.
  always_comb begin
    win = ptr;
    any = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (any) state_nx = S_DRAW;
      S_DRAW:  if (cnt == 4'd15) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      ptr   <= '0;
      gnt   <= '0;
      lat_x <= '0;
      lat_y <= '0;
      lat_c <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && any) begin
        gnt   <= win;
        ptr   <= (int'(win) == N_REQ - 1) ?
                 '0 : win + 1'b1;
        cnt   <= '0;
        lat_x <= req_x[8*int'(win) +: 8];
        lat_y <= req_y[7*int'(win) +: 7];
        lat_c <= req_erase[win] ?
                 3'b000 : req_colour[3*int'(win) +: 3];
      end else if (state == S_DRAW) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  // cnt[1:0] steps x, cnt[3:2] steps y: row-major order.
  always_comb begin
    done       = '0;
    busy       = (state != S_IDLE);
    vga_plot   = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    if (state == S_DRAW) begin
      vga_plot   = 1'b1;
      vga_x      = lat_x + {6'd0, cnt[1:0]};
      vga_y      = lat_y + {5'd0, cnt[3:2]};
      vga_colour = lat_c;
    end
    if (state == S_DONE) done[gnt] = 1'b1;
  end

endmodule

// File: tb/tb_square_draw_arbiter.sv
// tb_square_draw_arbiter: directed self-checking bench for
// square_draw_arbiter with four requesters.
module tb_square_draw_arbiter;

  logic        clk;
  logic        resetn;
  logic [3:0]  req;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [11:0] req_colour;
  logic [3:0]  req_erase;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int n_run;
  int n_fail;

  square_draw_arbiter #(.N_REQ(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .req_erase  (req_erase),
    .done       (done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i,
                         input logic [7:0] x,
                         input logic [6:0] y,
                         input logic [2:0] c,
                         input logic e);
    req_x[8*i +: 8]      = x;
    req_y[7*i +: 7]      = y;
    req_colour[3*i +: 3] = c;
    req_erase[i]         = e;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    req    = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Follows one square: latency to first pixel (in negedges),
  // 16 pixels, the done cycle, then the idle gap.
  task automatic draw_chk(input string tag,
                          input int gid,
                          input logic [7:0] x0,
                          input logic [6:0] y0,
                          input logic [2:0] col,
                          input int lat,
                          input int chg,
                          input logic [3:0] clr);
    int n;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [3:0] m;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vga_plot && n < 40);
    chk({tag, ".lat"}, n, lat);
    if (!vga_plot) return;
    chk({tag, ".done0"}, done, 0);
    for (int p = 0; p < 16; p++) begin
      if (p > 0) @(negedge clk);
      ex = x0 + 8'(p % 4);
      ey = y0 + 7'(p / 4);
      chk({tag, ".plot"}, vga_plot, 1);
      chk({tag, ".x"}, vga_x, ex);
      chk({tag, ".y"}, vga_y, ey);
      chk({tag, ".col"}, vga_colour, col);
      chk({tag, ".busy"}, busy, 1);
      if (p == chg) begin
        req_x[8*gid +: 8]      = ~x0;
        req_y[7*gid +: 7]      = ~y0;
        req_colour[3*gid +: 3] = ~col;
      end
    end
    @(negedge clk);
    m = 4'b0001 << gid;
    chk({tag, ".done"}, done, m);
    chk({tag, ".dplot"}, vga_plot, 0);
    chk({tag, ".dbusy"}, busy, 1);
    req = req & ~clr;
    @(negedge clk);
    chk({tag, ".gdone"}, done, 0);
    chk({tag, ".gplot"}, vga_plot, 0);
    chk({tag, ".gbusy"}, busy, 0);
    chk({tag, ".gx"}, vga_x, 0);
  endtask

  initial begin
    int n;
    n_run      = 0;
    n_fail     = 0;
    resetn     = 1'b0;
    req        = '0;
    req_x      = '0;
    req_y      = '0;
    req_colour = '0;
    req_erase  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.done", done, 0);
    chk("rst.busy", busy, 0);
    chk("rst.plot", vga_plot, 0);
    chk("rst.x", vga_x, 0);
    chk("rst.y", vga_y, 0);
    chk("rst.col", vga_colour, 0);
    @(posedge clk); #1 resetn = 1'b1;

    // single request
    @(posedge clk); #1;
    set_req(0, 8'd10, 7'd20, 3'd5, 1'b0);
    req = 4'b0001;
    draw_chk("single", 0, 8'd10, 7'd20, 3'd5, 2, -1, 4'b0001);

    // simultaneous from reset: 1 then 3
    do_reset();
    set_req(1, 8'd30, 7'd40, 3'd3, 1'b0);
    set_req(3, 8'd100, 7'd50, 3'd6, 1'b0);
    req = 4'b1010;
    draw_chk("sim1", 1, 8'd30, 7'd40, 3'd3, 2, -1, 4'b0010);
    draw_chk("sim3", 3, 8'd100, 7'd50, 3'd6, 1, -1, 4'b1000);

    // fairness, all held high; ptr is 0 here
    @(posedge clk); #1;
    set_req(0, 8'd0, 7'd0, 3'd1, 1'b0);
    set_req(1, 8'd16, 7'd8, 3'd2, 1'b0);
    set_req(2, 8'd32, 7'd16, 3'd3, 1'b0);
    set_req(3, 8'd48, 7'd24, 3'd4, 1'b0);
    req = 4'b1111;
    draw_chk("fair0", 0, 8'd0, 7'd0, 3'd1, 2, -1, 4'b0000);
    draw_chk("fair1", 1, 8'd16, 7'd8, 3'd2, 1, -1, 4'b0000);
    draw_chk("fair2", 2, 8'd32, 7'd16, 3'd3, 1, -1, 4'b0000);
    draw_chk("fair3", 3, 8'd48, 7'd24, 3'd4, 1, -1, 4'b0000);
    draw_chk("fair0b", 0, 8'd0, 7'd0, 3'd1, 1, -1, 4'b1111);

    // wrap and erase
    @(posedge clk); #1;
    set_req(2, 8'd254, 7'd126, 3'd7, 1'b1);
    req = 4'b0100;
    draw_chk("wrap", 2, 8'd254, 7'd126, 3'd0, 2, -1, 4'b0100);
    req_erase = '0;

    // inputs change at pixel 5
    @(posedge clk); #1;
    set_req(3, 8'd60, 7'd10, 3'd2, 1'b0);
    req = 4'b1000;
    draw_chk("chg", 3, 8'd60, 7'd10, 3'd2, 2, 5, 4'b1000);

    // reset at pixel 8 while serving requester 1
    @(posedge clk); #1;
    set_req(1, 8'd5, 7'd5, 3'd1, 1'b0);
    req = 4'b0010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vga_plot && n < 40);
    chk("abort.lat", n, 2);
    repeat (8) @(negedge clk);
    chk("abort.x8", vga_x, 8'd5);
    chk("abort.y8", vga_y, 7'd7);
    resetn = 1'b0;
    req    = '0;
    @(negedge clk);
    chk("abort.plot", vga_plot, 0);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    @(posedge clk); #1 resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort.nodone", done, 0);
    end
    // ptr back at 0: requester 0 beats 2
    @(posedge clk); #1;
    set_req(0, 8'd9, 7'd9, 3'd4, 1'b0);
    set_req(2, 8'd20, 7'd30, 3'd1, 1'b0);
    req = 4'b0101;
    draw_chk("post0", 0, 8'd9, 7'd9, 3'd4, 2, -1, 4'b0001);
    draw_chk("post2", 2, 8'd20, 7'd30, 3'd1, 1, -1, 4'b0100);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end

endmodule
